// File: rtl/alu_instr_encoder_if.sv
// Request/response bus of the ALU instruction encoder.
//   Request side : in_valid/in_ready handshake carrying ctrl code and operands.
//   Response side: out_valid/out_ready handshake carrying the encoded word.
// master = producer of requests and consumer of words; slave = the encoder.
interface alu_instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_ctrl;
  logic [3:0]  in_rdest;
  logic [3:0]  in_rsrc;
  logic [7:0]  in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;

  modport master (
    output in_valid, in_ctrl, in_rdest, in_rsrc, in_imm, out_ready,
    input  in_ready, out_valid, out_instr
  );

  modport slave (
    input  in_valid, in_ctrl, in_rdest, in_rsrc, in_imm, out_ready,
    output in_ready, out_valid, out_instr
  );
endinterface

// File: rtl/alu_instr_encoder.sv
// ALU instruction encoder: maps a 5-bit ALU control code plus operands to a
// 16-bit instruction word and buffers the words in a DEPTH-entry FIFO.
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   bus         slave side of alu_instr_encoder_if (request + output handshakes)
//   illegal     one-cycle pulse after an illegal control code was consumed
//   accept_cnt  legal words pushed since reset (wraps)
//   illegal_cnt illegal requests consumed since reset (wraps)
module alu_instr_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  alu_instr_encoder_if.slave bus,
  output logic               illegal,
  output logic [CNT_W-1:0]   accept_cnt,
  output logic [CNT_W-1:0]   illegal_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0]  PTR_ONE = AW'(1);
  localparam logic [AW:0]    CNT_ONE = (AW + 1)'(1);
  localparam logic [AW:0]    DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] STAT_ONE = CNT_W'(1);

  // Returns {legal, word}. R-type words carry opcode 0000 and an extension
  // field; I-type words carry the immediate in the low byte.
  function automatic logic [16:0] encode(
    input logic [4:0] ctrl,
    input logic [3:0] rdest,
    input logic [3:0] rsrc,
    input logic [7:0] imm
  );
    logic [16:0] r;
    case (ctrl)
      5'd0:    r = {1'b1, 4'b0000, rdest, 4'b0101, rsrc};
      5'd1:    r = {1'b1, 4'b0101, rdest, imm};
      5'd2:    r = {1'b1, 4'b0000, rdest, 4'b0110, rsrc};
      5'd3:    r = {1'b1, 4'b0110, rdest, imm};
      5'd4:    r = {1'b1, 4'b0000, rdest, 4'b1110, rsrc};
      5'd5:    r = {1'b1, 4'b0000, rdest, 4'b1001, rsrc};
      5'd6:    r = {1'b1, 4'b1001, rdest, imm};
      5'd7:    r = {1'b1, 4'b0000, rdest, 4'b1011, rsrc};
      5'd8:    r = {1'b1, 4'b1011, rdest, imm};
      5'd9:    r = {1'b1, 4'b0000, rdest, 4'b0001, rsrc};
      5'd10:   r = {1'b1, 4'b0001, rdest, imm};
      5'd11:   r = {1'b1, 4'b0000, rdest, 4'b0010, rsrc};
      5'd12:   r = {1'b1, 4'b0010, rdest, imm};
      5'd13:   r = {1'b1, 4'b0000, rdest, 4'b0011, rsrc};
      5'd14:   r = {1'b1, 4'b0011, rdest, imm};
      default: r = {1'b0, 16'h0000};
    endcase
    return r;
  endfunction

  logic [15:0]      mem_q [DEPTH];
  logic [15:0]      mem_d [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] accept_cnt_q, accept_cnt_d;
  logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

  logic        full, empty, fire, push, pop, enc_legal;
  logic [15:0] enc_word;

  assign full          = (count_q == DEPTH_C);
  assign empty         = (count_q == '0);
  assign bus.in_ready  = ~full;
  assign bus.out_valid = ~empty;
  assign bus.out_instr = mem_q[rd_ptr_q];
  assign illegal       = illegal_q;
  assign accept_cnt    = accept_cnt_q;
  assign illegal_cnt   = illegal_cnt_q;

  // Next-state for FIFO storage, pointers, occupancy, illegal pulse and counters.
  always_comb begin
    {enc_legal, enc_word} = encode(bus.in_ctrl, bus.in_rdest, bus.in_rsrc, bus.in_imm);
    // A full FIFO refuses requests even when the head is popped this cycle.
    fire          = bus.in_valid & ~full;
    push          = fire & enc_legal;
    pop           = ~empty & bus.out_ready;
    mem_d         = mem_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    illegal_d     = fire & ~enc_legal;
    accept_cnt_d  = accept_cnt_q;
    illegal_cnt_d = illegal_cnt_q;

    if (push) begin
      mem_d[wr_ptr_q] = enc_word;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
      accept_cnt_d    = accept_cnt_q + STAT_ONE;
    end else begin
      wr_ptr_d        = wr_ptr_q;
    end

    if (illegal_d) begin
      illegal_cnt_d = illegal_cnt_q + STAT_ONE;
    end else begin
      illegal_cnt_d = illegal_cnt_q;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset clears storage so out_instr reads zero afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 16'h0000;
      end
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      illegal_q     <= 1'b0;
      accept_cnt_q  <= '0;
      illegal_cnt_q <= '0;
    end else begin
      mem_q         <= mem_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      illegal_q     <= illegal_d;
      accept_cnt_q  <= accept_cnt_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

endmodule
